// File: rtl/rect_plotter.sv
// rect_plotter
//   Rectangle fill engine sitting between the game-control FSM and the
//   vga_adapter. One draw command (origin, size, colour) is taken per
//   cmd_valid/cmd_ready handshake and then rasterised one pixel per clock in
//   row-major order. Pixels falling outside the visible area (or whose
//   coordinate sum carries out of COORD_W bits) still take their cycle but
//   are not plotted.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   cmd_valid   draw command present on cmd_* inputs
//   cmd_ready   engine can accept a command (idle)
//   cmd_x/y     top-left corner of the rectangle
//   cmd_w/h     rectangle size in pixels (0 = empty command)
//   cmd_colour  fill colour
//   x/y         pixel coordinate to vga_adapter (registered)
//   colour      pixel colour to vga_adapter (registered)
//   plot        write strobe to vga_adapter (registered)
//   busy        command being rasterised
//   done        one-cycle pulse when a command completes
module rect_plotter #(
  parameter int unsigned COORD_W  = 8,
  parameter int unsigned COLOUR_W = 3,
  parameter int unsigned MAX_X    = 159,
  parameter int unsigned MAX_Y    = 119
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [COORD_W-1:0]  cmd_x,
  input  logic [COORD_W-1:0]  cmd_y,
  input  logic [COORD_W-1:0]  cmd_w,
  input  logic [COORD_W-1:0]  cmd_h,
  input  logic [COLOUR_W-1:0] cmd_colour,
  output logic [COORD_W-1:0]  x,
  output logic [COORD_W-1:0]  y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam logic [COORD_W:0] LIM_X = (COORD_W+1)'(MAX_X);
  localparam logic [COORD_W:0] LIM_Y = (COORD_W+1)'(MAX_Y);

  // DRAIN is the cycle in which the final pixel sits on the registered
  // outputs; done therefore trails the last plot by one clock. Empty
  // commands pass through DRAIN too, so done always lands one clock after
  // the last pixel slot (or after acceptance when there are none).
  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [COORD_W-1:0]  org_x, org_y, size_w, size_h;
  logic [COORD_W-1:0]  col, row;
  logic [COLOUR_W-1:0] fill;

  logic [COORD_W:0] sum_x, sum_y;
  logic             clip;
  logic             last_col, last_row;
  logic             accept;

  // Pixel address and clip decision for the current (col,row)
  always_comb begin
    sum_x    = {1'b0, org_x} + {1'b0, col};
    sum_y    = {1'b0, org_y} + {1'b0, row};
    clip     = sum_x[COORD_W] || sum_y[COORD_W] || (sum_x > LIM_X) || (sum_y > LIM_Y);
    last_col = (col == size_w - COORD_W'(1));
    last_row = (row == size_h - COORD_W'(1));
    accept   = (state == IDLE) && cmd_valid;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and status decode
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_next = ((cmd_w == '0) || (cmd_h == '0)) ? DRAIN : DRAW;
        end
      end
      DRAW: begin
        busy = 1'b1;
        if (last_col && last_row) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command latch, raster counters and registered pixel outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      org_x  <= '0;
      org_y  <= '0;
      size_w <= '0;
      size_h <= '0;
      fill   <= '0;
      col    <= '0;
      row    <= '0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else begin
      if (accept) begin
        org_x  <= cmd_x;
        org_y  <= cmd_y;
        size_w <= cmd_w;
        size_h <= cmd_h;
        fill   <= cmd_colour;
        col    <= '0;
        row    <= '0;
      end else if (state == DRAW) begin
        if (last_col) begin
          col <= '0;
          row <= row + COORD_W'(1);
        end else begin
          col <= col + COORD_W'(1);
        end
      end

      if (state == DRAW) begin
        x      <= sum_x[COORD_W-1:0];
        y      <= sum_y[COORD_W-1:0];
        colour <= fill;
        plot   <= !clip;
      end else begin
        plot   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rect_plotter.sv
// tb_rect_plotter
//   Scoreboard bench for rect_plotter. The driver pushes the expected pixel
//   stream (coordinates, colour and the clock edge each pixel must appear
//   after) and the expected done edge for every accepted command; a monitor
//   on the falling edge pops and compares whenever plot or done is seen.
module tb_rect_plotter;

  localparam int CW   = 8;
  localparam int KW   = 3;
  localparam int MX   = 159;
  localparam int MY   = 119;
  localparam int WAIT = 30000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [CW-1:0] cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
  logic [KW-1:0] cmd_colour = '0;
  logic [CW-1:0] x, y;
  logic [KW-1:0] colour;
  logic          plot, busy, done;

  rect_plotter #(.COORD_W(CW), .COLOUR_W(KW), .MAX_X(MX), .MAX_Y(MY)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_colour(cmd_colour),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;

  // Edge counter: sampled on the falling edge it equals the number of the
  // rising edge just passed.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [KW-1:0] c;
    int            cyc;
  } pix_t;

  pix_t pix_q[$];
  int   done_q[$];
  pix_t mon_p;
  int   mon_d;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
  endtask

  // Reference model: walk the rectangle row by row; every slot takes one
  // clock, only in-range slots produce a plot.
  task automatic expect_cmd(input int t, input int cx, input int cy,
                            input int cw, input int ch, input int cc);
    int   n = 0;
    pix_t p;
    for (int r = 0; r < ch; r++) begin
      for (int c = 0; c < cw; c++) begin
        if ((cx + c) <= MX && (cy + r) <= MY) begin
          p.x   = CW'(cx + c);
          p.y   = CW'(cy + r);
          p.c   = KW'(cc);
          p.cyc = t + 1 + n;
          pix_q.push_back(p);
        end
        n++;
      end
    end
    done_q.push_back(t + cw * ch + 1);
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance
  // with t = the accepting rising edge.
  task automatic send(input int cx, input int cy, input int cw, input int ch,
                      input int cc, output int t);
    int n = 0;
    cmd_x      = CW'(cx);
    cmd_y      = CW'(cy);
    cmd_w      = CW'(cw);
    cmd_h      = CW'(ch);
    cmd_colour = KW'(cc);
    cmd_valid  = 1'b1;
    while (!cmd_ready && n < WAIT) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", longint'(cmd_ready), 1);
    t = cyc + 1;
    if (cmd_ready) expect_cmd(t, cx, cy, cw, ch, cc);
    @(negedge clk);
    cmd_valid  = 1'b0;
    cmd_x      = CW'($urandom);
    cmd_y      = CW'($urandom);
    cmd_w      = CW'($urandom);
    cmd_h      = CW'($urandom);
    cmd_colour = KW'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((pix_q.size() != 0 || done_q.size() != 0 || !cmd_ready) && n < WAIT) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", longint'(n < WAIT), 1);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (plot) begin
        chk("plot_expected", longint'(pix_q.size() != 0), 1);
        if (pix_q.size() != 0) begin
          mon_p = pix_q.pop_front();
          chk("pixel_xyc", {x, y, colour}, {mon_p.x, mon_p.y, mon_p.c});
          chk("pixel_edge", cyc, mon_p.cyc);
        end
        chk("busy_with_plot", busy, 1);
      end else if (pix_q.size() != 0 && pix_q[0].cyc <= cyc) begin
        chk("plot_at_edge", plot, 1);
        mon_p = pix_q.pop_front();
      end

      if (done) begin
        chk("done_expected", longint'(done_q.size() != 0), 1);
        if (done_q.size() != 0) begin
          mon_d = done_q.pop_front();
          chk("done_edge", cyc, mon_d);
        end
        chk("ready_in_done", cmd_ready, 0);
        chk("busy_in_done", busy, 0);
      end else if (done_q.size() != 0 && done_q[0] <= cyc) begin
        chk("done_at_edge", done, 1);
        mon_d = done_q.pop_front();
      end

      if (busy && cmd_ready) chk("ready_while_busy", cmd_ready, 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2;
    int cx, cy, cw, ch, cc;

    repeat (3) @(negedge clk);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_colour", colour, 0);
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    reset = 1'b0;
    @(negedge clk);

    // Paddle
    send(72, 110, 12, 2, 7, t);
    chk("paddle_ready_low", cmd_ready, 0);
    chk("paddle_busy", busy, 1);
    wait_idle();

    // Full-screen clear
    send(0, 0, 160, 120, 0, t);
    wait_idle();

    // Empty command
    send(10, 10, 0, 5, 2, t);
    chk("empty_plot", plot, 0);
    chk("empty_ready_t", cmd_ready, 0);
    @(negedge clk);
    chk("empty_done_t1", done, 1);
    chk("empty_ready_t1", cmd_ready, 0);
    @(negedge clk);
    chk("empty_ready_t2", cmd_ready, 1);
    chk("empty_done_t2", done, 0);
    wait_idle();

    // Clipping at the bottom-right corner, and carry-out of the sum
    send(158, 118, 4, 3, 5, t);
    wait_idle();
    send(200, 100, 70, 1, 6, t);
    wait_idle();
    send(10, 250, 2, 10, 3, t);
    wait_idle();

    // Backpressure: second command held valid while the first is drawn
    send(20, 30, 5, 3, 4, t);
    chk("bp_ready_low", cmd_ready, 0);
    send(40, 50, 3, 4, 1, t2);
    chk("bp_second_after_first", longint'(t2 > t + 5 * 3 + 1), 1);
    wait_idle();

    // Randomised commands
    for (int i = 0; i < 30; i++) begin
      cx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(140, 255)) : int'($urandom_range(0, 159));
      cy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 255)) : int'($urandom_range(0, 119));
      cw = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 24));
      ch = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12));
      cc = int'($urandom_range(0, 7));
      send(cx, cy, cw, ch, cc, t);
      if ($urandom_range(0, 1) == 1) wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();

    // Reset during the fifth pixel of the paddle
    send(72, 110, 12, 2, 7, t);
    repeat (5) @(negedge clk);
    chk("rmd_plot_before", plot, 1);
    chk("rmd_x_before", x, 76);
    #2 reset = 1'b1;
    #1;
    chk("rmd_plot", plot, 0);
    chk("rmd_busy", busy, 0);
    chk("rmd_done", done, 0);
    pix_q.delete();
    done_q.delete();
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rmd_ready_after", cmd_ready, 1);
    repeat (20) @(negedge clk);
    chk("rmd_quiet_done", done, 0);
    chk("rmd_quiet_busy", busy, 0);

    chk("pix_q_empty", pix_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
